palette_dac: RTL and testbench
==============================

PALETTE_DAC -- requirements
Module: palette_dac

Interface
REQ-001 Parameter IDX_W, default 4, pixel index width; legal range 4..8.
REQ-002 Parameter COMP_W, default 6, red/blue component width; legal range 2..8.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 video  input  IDX_W  pixel palette index.
REQ-006 blank  input  1  high forces black output.
REQ-007 bus_addr  input  2  register select: 0 = write index, 1 = data, 2 = read index, 3 = pixel mask.
REQ-008 bus_wr  input  1  one-cycle write strobe.
REQ-009 bus_rd  input  1  one-cycle read strobe.
REQ-010 bus_din  input  8  write data.
REQ-011 bus_dout  output  8  registered read data.
REQ-012 init_busy  output  1  high while the palette is being loaded with defaults.
REQ-013 red  output  COMP_W  red level.
REQ-014 green  output  COMP_W+1  green level; LSB equals the green MSB.
REQ-015 blue  output  COMP_W  blue level.

Function
REQ-016 Palette SHALL be 2^IDX_W entries x 3*COMP_W bits.
REQ-017 Level codes SHALL be 0 = all zeros, 1 = "01" repeated MSB-first truncated to COMP_W, 2 = "10" repeated likewise, 3 = all ones.
REQ-018 Default entry i (taking i mod 16) SHALL be standard CGA: I = bit3; R/G/B = bits 2/1/0; a set colour bit gives level 2+I, a clear one gives level I; entry 6 green SHALL be level 1 (brown).
REQ-019 Init FSM states SHALL be INIT and RUN; reset enters INIT with counter 0.
REQ-020 INIT SHALL write one default entry per clock, 0 through 2^IDX_W-1, then enter RUN; init_busy SHALL be high exactly in INIT.
REQ-021 During INIT, bus writes SHALL be dropped, bus_dout SHALL be 0, and RGB outputs SHALL be 0.
REQ-022 Pixel pipeline latency SHALL be 2 clocks: stage 1 registers (video & mask) and blank; stage 2 registers the looked-up RGB, or zero if the stage-1 blank was set.
REQ-023 Write to addr 0 SHALL load widx and reset the write component counter to R, discarding any partial triple.
REQ-024 Writes to addr 1 SHALL capture bus_din[COMP_W-1:0] in the R, then G, then B holding registers.
REQ-025 On the B write, the full triple SHALL commit to entry widx, widx SHALL increment mod 2^IDX_W, and the counter SHALL return to R.
REQ-026 Write to addr 2 SHALL load ridx and reset the read component counter to R.
REQ-027 Read of addr 1 SHALL return the entry-ridx component selected by the read counter, zero-extended, then advance the counter R->G->B.
REQ-028 After B is returned, ridx SHALL increment mod 2^IDX_W and the read counter SHALL return to R.
REQ-029 Reads of addrs 0, 2 and 3 SHALL return widx, ridx and mask, zero-extended, with no side effects.
REQ-030 Write to addr 3 SHALL load the mask from bus_din[IDX_W-1:0].
REQ-031 bus_dout SHALL update the clock after bus_rd and otherwise hold its value.
REQ-032 When bus_rd and bus_wr are asserted together, the write SHALL execute and the read SHALL be ignored.
REQ-033 When a commit and a pixel lookup hit the same entry in the same cycle, the pixel SHALL see the old value; the new value SHALL be visible from the next cycle.
REQ-034 Write and read counters and indices SHALL be independent.

Reset
REQ-035 reset_n low SHALL immediately clear red/green/blue, bus_dout, widx, ridx, both counters and the holding registers, set mask to all ones, and enter INIT.
REQ-036 Reset asserted mid-INIT or mid-triple SHALL abort the operation and restart INIT from entry 0 after release.

Verification
REQ-037 Release reset, defaults: init_busy high for 16 clocks; then video=6, blank=0 gives red=101010, green=0101010, blue=000000 two clocks later.
REQ-038 Write sequence: addr0<-5, addr1<-3F,00,15; video=5 gives red=111111, green=0000000, blue=010101; widx reads 6.
REQ-039 Readback: addr2<-F, three reads of addr1 return 3F,3F,3F; a fourth read returns entry 0 red (00); ridx wraps to 0 after 15.
REQ-040 Mask and blank: mask<-7, video=F gives the entry-7 colour; blank=1 gives all-zero RGB two clocks later.
REQ-041 Abort: addr1<-11,22, then addr0<-2, then addr1<-01,02,03: entry 2 = (01,02,03) and entry 0 is unchanged.
REQ-042 Collision and reset: a commit to entry 4 while video=4 shows the old colour first, then the new; reset mid-INIT restarts with a full 2^IDX_W-cycle init_busy.

Source files
------------

// File: rtl/palette_dac.sv
// Colour palette DAC. On reset it loads CGA defaults into the palette, then serves
// a 2-stage pixel lookup and a byte-wide register port for palette and mask access.
module palette_dac #(
  parameter int IDX_W  = 4,
  parameter int COMP_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IDX_W-1:0]  video,
  input  logic              blank,
  input  logic [1:0]        bus_addr,
  input  logic              bus_wr,
  input  logic              bus_rd,
  input  logic [7:0]        bus_din,
  output logic [7:0]        bus_dout,
  output logic              init_busy,
  output logic [COMP_W-1:0] red,
  output logic [COMP_W:0]   green,
  output logic [COMP_W-1:0] blue
);
  localparam int PAL_N   = 1 << IDX_W;
  localparam int ENTRY_W = 3 * COMP_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  typedef enum logic [1:0] {CMP_R, CMP_G, CMP_B} comp_t;

  // Level 1 is "0101..." and level 2 "1010..." counted from the MSB.
  function automatic logic [COMP_W-1:0] level_code(input logic [1:0] lvl);
    logic [COMP_W-1:0] v;
    for (int j = 0; j < COMP_W; j++) begin
      case (lvl)
        2'd0:    v[j] = 1'b0;
        2'd1:    v[j] = ((COMP_W - 1 - j) % 2) == 1;
        2'd2:    v[j] = ((COMP_W - 1 - j) % 2) == 0;
        default: v[j] = 1'b1;
      endcase
    end
    return v;
  endfunction

  // Level index is {colour bit, intensity bit}; entry 6 uses dim green for brown.
  function automatic logic [ENTRY_W-1:0] default_entry(input logic [3:0] c);
    logic [1:0] lr, lg, lb;
    lr = {c[2], c[3]};
    lg = (c == 4'd6) ? 2'd1 : {c[1], c[3]};
    lb = {c[0], c[3]};
    return {level_code(lr), level_code(lg), level_code(lb)};
  endfunction

  logic [ENTRY_W-1:0] pal_mem [PAL_N];

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   init_cnt_q, init_cnt_d;
  logic [IDX_W-1:0]   widx_q, widx_d, ridx_q, ridx_d, mask_q, mask_d;
  comp_t              wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [COMP_W-1:0]  hold_r_q, hold_r_d, hold_g_q, hold_g_d;
  logic [7:0]         bus_dout_q, bus_dout_d;
  logic [IDX_W-1:0]   pix_idx_q, pix_idx_d;
  logic               blank_s1_q, blank_s1_d;
  logic [ENTRY_W-1:0] rgb_q, rgb_d;

  logic               mem_we;
  logic [IDX_W-1:0]   mem_waddr;
  logic [ENTRY_W-1:0] mem_wdata, pal_pix, pal_rd;
  logic               unused_din;

  assign unused_din = ^bus_din;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    widx_d     = widx_q;
    ridx_d     = ridx_q;
    mask_d     = mask_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    hold_r_d   = hold_r_q;
    hold_g_d   = hold_g_q;
    bus_dout_d = bus_dout_q;
    pix_idx_d  = video & mask_q;
    blank_s1_d = blank;
    mem_we     = 1'b0;
    mem_waddr  = widx_q;
    mem_wdata  = {hold_r_q, hold_g_q, bus_din[COMP_W-1:0]};
    pal_pix    = pal_mem[pix_idx_q];
    pal_rd     = pal_mem[ridx_q];
    rgb_d      = '0;

    if (state_q == ST_INIT) begin
      mem_we     = 1'b1;
      mem_waddr  = init_cnt_q;
      mem_wdata  = default_entry(init_cnt_q[3:0]);
      init_cnt_d = init_cnt_q + 1'b1;
      bus_dout_d = '0;
      if (init_cnt_q == IDX_W'(PAL_N - 1)) state_d = ST_RUN;
    end else begin
      // A same-cycle commit lands after this lookup, so pixels see the old entry.
      rgb_d = blank_s1_q ? '0 : pal_pix;
      if (bus_wr) begin
        case (bus_addr)
          2'd0: begin
            widx_d = bus_din[IDX_W-1:0];
            wcnt_d = CMP_R;
          end
          2'd1: begin
            case (wcnt_q)
              CMP_R: begin
                hold_r_d = bus_din[COMP_W-1:0];
                wcnt_d   = CMP_G;
              end
              CMP_G: begin
                hold_g_d = bus_din[COMP_W-1:0];
                wcnt_d   = CMP_B;
              end
              default: begin
                mem_we = 1'b1;
                widx_d = widx_q + 1'b1;
                wcnt_d = CMP_R;
              end
            endcase
          end
          2'd2: begin
            ridx_d = bus_din[IDX_W-1:0];
            rcnt_d = CMP_R;
          end
          default: mask_d = bus_din[IDX_W-1:0];
        endcase
      end else if (bus_rd) begin
        case (bus_addr)
          2'd0: bus_dout_d = 8'(widx_q);
          2'd1: begin
            case (rcnt_q)
              CMP_R: begin
                bus_dout_d = 8'(pal_rd[3*COMP_W-1:2*COMP_W]);
                rcnt_d     = CMP_G;
              end
              CMP_G: begin
                bus_dout_d = 8'(pal_rd[2*COMP_W-1:COMP_W]);
                rcnt_d     = CMP_B;
              end
              default: begin
                bus_dout_d = 8'(pal_rd[COMP_W-1:0]);
                ridx_d     = ridx_q + 1'b1;
                rcnt_d     = CMP_R;
              end
            endcase
          end
          2'd2:    bus_dout_d = 8'(ridx_q);
          default: bus_dout_d = 8'(mask_q);
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) pal_mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      widx_q     <= '0;
      ridx_q     <= '0;
      mask_q     <= '1;
      wcnt_q     <= CMP_R;
      rcnt_q     <= CMP_R;
      hold_r_q   <= '0;
      hold_g_q   <= '0;
      bus_dout_q <= '0;
      pix_idx_q  <= '0;
      blank_s1_q <= 1'b0;
      rgb_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      widx_q     <= widx_d;
      ridx_q     <= ridx_d;
      mask_q     <= mask_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      hold_r_q   <= hold_r_d;
      hold_g_q   <= hold_g_d;
      bus_dout_q <= bus_dout_d;
      pix_idx_q  <= pix_idx_d;
      blank_s1_q <= blank_s1_d;
      rgb_q      <= rgb_d;
    end
  end

  assign init_busy = (state_q == ST_INIT);
  assign bus_dout  = bus_dout_q;
  assign red       = rgb_q[3*COMP_W-1:2*COMP_W];
  assign green     = {rgb_q[2*COMP_W-1:COMP_W], rgb_q[2*COMP_W-1]};
  assign blue      = rgb_q[COMP_W-1:0];
endmodule

// File: tb/tb_palette_dac.sv
// Bench for palette_dac: literal default-colour vectors, a pixel scoreboard and
// hand-written bus sequences for triples, readback, masking, collision and reset.
module tb_palette_dac;
  localparam int IDX_W  = 4;
  localparam int COMP_W = 6;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [IDX_W-1:0] video;
  logic             blank;
  logic [1:0]       bus_addr;
  logic             bus_wr, bus_rd;
  logic [7:0]       bus_din, bus_dout;
  logic             init_busy;
  logic [5:0]       red, blue;
  logic [6:0]       green;

  palette_dac #(.IDX_W(IDX_W), .COMP_W(COMP_W)) dut (
    .clk(clk), .reset_n(reset_n), .video(video), .blank(blank),
    .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_din(bus_din),
    .bus_dout(bus_dout), .init_busy(init_busy), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    int         due;
    logic [5:0] r;
    logic [6:0] g;
    logic [5:0] b;
  } pix_exp_t;
  pix_exp_t sb_q[$];

  typedef struct {
    logic [3:0] v;
    logic       bl;
    logic [5:0] r;
    logic [6:0] g;
    logic [5:0] b;
  } vec_t;
  vec_t vecs[10];

  logic [17:0] exp_pal[16];
  logic [3:0]  tb_mask;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  function automatic logic [17:0] cga(input int i);
    logic [5:0] lv[4];
    int in;
    lv[0] = 6'h00; lv[1] = 6'h15; lv[2] = 6'h2A; lv[3] = 6'h3F;
    in = (i >> 3) & 1;
    return {lv[((i >> 2) & 1) * 2 + in],
            (i == 6) ? lv[1] : lv[((i >> 1) & 1) * 2 + in],
            lv[(i & 1) * 2 + in]};
  endfunction

  function automatic logic [6:0] g7(input logic [5:0] g);
    return {g, g[5]};
  endfunction

  // Scoreboard monitor: each entry is due two clocks after it was driven.
  initial begin
    pix_exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        check(e.name, {13'd0, red, green, blue}, {13'd0, e.r, e.g, e.b});
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_pix(input string name, input logic [3:0] v, input logic bl,
                          input logic [5:0] r, input logic [6:0] g, input logic [5:0] b);
    pix_exp_t e;
    video = v;
    blank = bl;
    e.name = name; e.due = cyc + 2; e.r = r; e.g = g; e.b = b;
    sb_q.push_back(e);
  endtask

  task automatic pix_model(input string name, input logic [3:0] v, input logic bl);
    logic [17:0] e;
    e = exp_pal[v & tb_mask];
    if (bl) push_pix(name, v, bl, 6'h00, 7'h00, 6'h00);
    else    push_pix(name, v, bl, e[17:12], g7(e[11:6]), e[5:0]);
  endtask

  task automatic drain();
    for (int k = 0; k < 12; k++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    bus_addr = a;
    bus_din  = d;
    bus_wr   = 1'b1;
    tick();
    bus_wr   = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    bus_addr = a;
    bus_rd   = 1'b1;
    tick();
    bus_rd   = 1'b0;
    d        = bus_dout;
  endtask

  // Counts init_busy clocks from reset release; optionally tries a mask write meanwhile.
  task automatic wait_init(input bit drop_test);
    int n = 0;
    if (drop_test) begin
      bus_addr = 2'd3; bus_din = 8'h00; bus_wr = 1'b1;
    end
    while (init_busy === 1'b1 && n < 100) begin
      n++;
      if (drop_test && n == 8) begin
        check("init_rgb_zero", {13'd0, red, green, blue}, 32'd0);
        check("init_dout_zero", {24'd0, bus_dout}, 32'd0);
      end
      @(negedge clk);
    end
    bus_wr = 1'b0;
    check("init_busy_len", n, 16);
  endtask

  initial begin
    logic [7:0] d;
    video = 4'hF; blank = 1'b0; bus_addr = 2'd0; bus_wr = 1'b0; bus_rd = 1'b0;
    bus_din = 8'h00; reset_n = 1'b0;
    for (int i = 0; i < 16; i++) exp_pal[i] = cga(i);
    tb_mask = 4'hF;

    vecs[0] = '{4'h6, 1'b0, 6'h2A, 7'h2A, 6'h00};
    vecs[1] = '{4'h0, 1'b0, 6'h00, 7'h00, 6'h00};
    vecs[2] = '{4'hF, 1'b0, 6'h3F, 7'h7F, 6'h3F};
    vecs[3] = '{4'h1, 1'b0, 6'h00, 7'h00, 6'h2A};
    vecs[4] = '{4'h9, 1'b0, 6'h15, 7'h2A, 6'h3F};
    vecs[5] = '{4'h7, 1'b0, 6'h2A, 7'h55, 6'h2A};
    vecs[6] = '{4'h8, 1'b0, 6'h15, 7'h2A, 6'h15};
    vecs[7] = '{4'hE, 1'b0, 6'h3F, 7'h7F, 6'h15};
    vecs[8] = '{4'h3, 1'b1, 6'h00, 7'h00, 6'h00};
    vecs[9] = '{4'h4, 1'b0, 6'h2A, 7'h00, 6'h00};

    repeat (3) tick();
    check("rst_rgb", {13'd0, red, green, blue}, 32'd0);
    check("rst_dout", {24'd0, bus_dout}, 32'd0);
    check("rst_busy", {31'd0, init_busy}, 32'd1);

    reset_n = 1'b1;
    wait_init(1'b1);
    bus_read(2'd3, d); check("mask_after_init", {24'd0, d}, 32'h0F);
    bus_read(2'd0, d); check("widx_after_init", {24'd0, d}, 32'h00);

    for (int i = 0; i < 10; i++) begin
      push_pix($sformatf("vec%0d", i), vecs[i].v, vecs[i].bl, vecs[i].r, vecs[i].g, vecs[i].b);
      tick();
    end
    drain();

    // Triple write to entry 5.
    bus_write(2'd0, 8'h05);
    bus_write(2'd1, 8'h3F); bus_write(2'd1, 8'h00); bus_write(2'd1, 8'h15);
    exp_pal[5] = {6'h3F, 6'h00, 6'h15};
    push_pix("entry5_new", 4'h5, 1'b0, 6'h3F, 7'h00, 6'h15);
    tick(); drain();
    bus_read(2'd0, d); check("widx_inc", {24'd0, d}, 32'h06);

    // Readback across the wrap.
    bus_write(2'd2, 8'h0F);
    bus_read(2'd1, d); check("rd_F_r", {24'd0, d}, 32'h3F);
    bus_read(2'd1, d); check("rd_F_g", {24'd0, d}, 32'h3F);
    bus_read(2'd1, d); check("rd_F_b", {24'd0, d}, 32'h3F);
    bus_read(2'd1, d); check("rd_0_r", {24'd0, d}, 32'h00);
    bus_read(2'd2, d); check("ridx_wrap", {24'd0, d}, 32'h00);

    // Mask and blank.
    bus_write(2'd3, 8'h07); tb_mask = 4'h7;
    pix_model("mask_F_to_7", 4'hF, 1'b0); tick();
    push_pix("mask_F_to_7_lit", 4'hF, 1'b0, 6'h2A, 7'h55, 6'h2A); tick();
    pix_model("blank_F", 4'hF, 1'b1); tick();
    drain();
    bus_read(2'd3, d); check("mask_rd", {24'd0, d}, 32'h07);
    bus_write(2'd3, 8'h0F); tb_mask = 4'hF;

    // Partial triple discarded by an index write.
    bus_write(2'd1, 8'h11); bus_write(2'd1, 8'h22);
    bus_write(2'd0, 8'h02);
    bus_write(2'd1, 8'h01); bus_write(2'd1, 8'h02); bus_write(2'd1, 8'h03);
    exp_pal[2] = {6'h01, 6'h02, 6'h03};
    pix_model("abort_e2", 4'h2, 1'b0); tick();
    pix_model("abort_e0", 4'h0, 1'b0); tick();
    pix_model("abort_e6", 4'h6, 1'b0); tick();
    drain();
    bus_read(2'd0, d); check("abort_widx", {24'd0, d}, 32'h03);
    bus_write(2'd2, 8'h02);
    bus_read(2'd1, d); check("rd_2_r", {24'd0, d}, 32'h01);
    bus_read(2'd1, d); check("rd_2_g", {24'd0, d}, 32'h02);
    bus_read(2'd1, d); check("rd_2_b", {24'd0, d}, 32'h03);
    bus_write(2'd2, 8'h00);
    bus_read(2'd1, d); check("rd_0_r_again", {24'd0, d}, 32'h00);

    // Simultaneous read and write: write wins, dout holds.
    bus_read(2'd0, d);
    bus_addr = 2'd3; bus_din = 8'h0E; bus_wr = 1'b1; bus_rd = 1'b1;
    tick();
    bus_wr = 1'b0; bus_rd = 1'b0;
    check("rdwr_dout_hold", {24'd0, bus_dout}, 32'h03);
    tb_mask = 4'hE;
    bus_read(2'd3, d); check("rdwr_mask", {24'd0, d}, 32'h0E);
    bus_write(2'd3, 8'h0F); tb_mask = 4'hF;

    // Commit to entry 4 while entry 4 is on screen.
    bus_write(2'd0, 8'h04);
    bus_write(2'd1, 8'h0A); bus_write(2'd1, 8'h0B);
    pix_model("coll_old", 4'h4, 1'b0);
    tick();
    bus_addr = 2'd1; bus_din = 8'h0C; bus_wr = 1'b1;
    exp_pal[4] = {6'h0A, 6'h0B, 6'h0C};
    pix_model("coll_new", 4'h4, 1'b0);
    tick();
    bus_wr = 1'b0;
    pix_model("coll_new2", 4'h4, 1'b0);
    tick();
    drain();

    // Asynchronous reset, then a reset during INIT.
    bus_read(2'd0, d); check("pre_rst_widx", {24'd0, d}, 32'h05);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_rgb", {13'd0, red, green, blue}, 32'd0);
    check("async_rst_dout", {24'd0, bus_dout}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) tick();
    check("mid_init_busy", {31'd0, init_busy}, 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    wait_init(1'b0);
    for (int i = 0; i < 16; i++) exp_pal[i] = cga(i);
    bus_read(2'd0, d); check("rst_widx", {24'd0, d}, 32'h00);
    bus_read(2'd3, d); check("rst_mask", {24'd0, d}, 32'h0F);
    pix_model("rst_e4", 4'h4, 1'b0); tick();
    pix_model("rst_e5", 4'h5, 1'b0); tick();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
